// File: rtl/calc2_port_issuer.sv
// Requester-side driver for one CALC2 port: issues two-cycle requests, tracks
// outstanding tags, and reports each response or timeout as a single completion.
module calc2_port_issuer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  c_clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [3:0]            op_cmd,
  input  logic [DATA_W-1:0]     op_d1,
  input  logic [DATA_W-1:0]     op_d2,
  output logic [3:0]            req_cmd_out,
  output logic [DATA_W-1:0]     req_data_out,
  output logic [TAG_W-1:0]      req_tag_out,
  input  logic [1:0]            rsp_resp_in,
  input  logic [DATA_W-1:0]     rsp_data_in,
  input  logic [TAG_W-1:0]      rsp_tag_in,
  output logic                  cpl_valid,
  output logic [1:0]            cpl_resp,
  output logic [DATA_W-1:0]     cpl_data,
  output logic [TAG_W-1:0]      cpl_tag,
  output logic                  cpl_timeout,
  output logic                  err_spurious,
  output logic [(1<<TAG_W)-1:0] busy_tags
);

  localparam int unsigned NTAG  = 1 << TAG_W;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE1 = 2'd1;
  localparam logic [1:0] S_ISSUE2 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              op_ready_q, op_ready_d;
  logic [3:0]        req_cmd_q, req_cmd_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [DATA_W-1:0] d2_q, d2_d;

  logic [NTAG-1:0]   busy_q, busy_d;
  logic [NTAG-1:0]   armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q [NTAG];
  logic [CNT_W-1:0]  cnt_d [NTAG];

  logic              cpl_valid_q, cpl_valid_d;
  logic [1:0]        cpl_resp_q, cpl_resp_d;
  logic [DATA_W-1:0] cpl_data_q, cpl_data_d;
  logic [TAG_W-1:0]  cpl_tag_q, cpl_tag_d;
  logic              cpl_timeout_q, cpl_timeout_d;
  logic              err_spur_q, err_spur_d;

  logic              rsp_valid_c, rsp_hit_c, rsp_spur_c;
  logic [NTAG-1:0]   expired_c;
  logic              exp_any_c, fire_to_c;
  logic [TAG_W-1:0]  exp_idx_c;
  logic [TAG_W-1:0]  free_idx_c;
  logic              handshake_c, alloc_c;
  logic [NTAG-1:0]   alloc_mask_c, retire_c, arm_now_c;

  // Classify the sampled response against the registered busy mask.
  always_comb begin
    rsp_valid_c = (rsp_resp_in != 2'd0);
    rsp_hit_c   = rsp_valid_c && busy_q[rsp_tag_in];
    rsp_spur_c  = rsp_valid_c && !busy_q[rsp_tag_in];
  end

  // Expired tags; a same-cycle response on the same tag wins over its timeout.
  always_comb begin
    expired_c = '0;
    for (int unsigned t = 0; t < NTAG; t++) begin
      expired_c[t] = busy_q[t] && armed_q[t] && (cnt_q[t] == CNT_MAX) &&
                     !(rsp_hit_c && (rsp_tag_in == TAG_W'(t)));
    end
    exp_any_c = |expired_c;
    exp_idx_c = '0;
    for (int t = int'(NTAG) - 1; t >= 0; t--) begin
      if (expired_c[t]) exp_idx_c = TAG_W'(t);
    end
    fire_to_c = exp_any_c && !rsp_hit_c;
  end

  // Lowest-numbered free tag from the registered mask.
  always_comb begin
    free_idx_c = '0;
    for (int t = int'(NTAG) - 1; t >= 0; t--) begin
      if (!busy_q[t]) free_idx_c = TAG_W'(t);
    end
  end

  // Request FSM: next state and next request-bus values.
  always_comb begin
    state_d     = state_q;
    req_cmd_d   = 4'd0;
    req_data_d  = '0;
    req_tag_d   = '0;
    d2_d        = d2_q;
    handshake_c = op_valid && op_ready_q;
    alloc_c     = handshake_c && (op_cmd != 4'd0);
    case (state_q)
      S_IDLE, S_ISSUE2: begin
        if (alloc_c) begin
          state_d    = S_ISSUE1;
          req_cmd_d  = op_cmd;
          req_data_d = op_d1;
          req_tag_d  = free_idx_c;
          d2_d       = op_d2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE1: begin
        state_d    = S_ISSUE2;
        req_cmd_d  = 4'd0;
        req_data_d = d2_q;
        req_tag_d  = req_tag_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tag bookkeeping, timeout counters and completion selection.
  always_comb begin
    cpl_valid_d   = 1'b0;
    cpl_resp_d    = 2'd0;
    cpl_data_d    = '0;
    cpl_tag_d     = '0;
    cpl_timeout_d = 1'b0;
    err_spur_d    = rsp_spur_c;
    alloc_mask_c  = '0;
    retire_c      = '0;
    arm_now_c     = '0;
    for (int unsigned t = 0; t < NTAG; t++) begin
      alloc_mask_c[t] = alloc_c && (free_idx_c == TAG_W'(t));
      retire_c[t]     = (rsp_hit_c && (rsp_tag_in == TAG_W'(t))) ||
                        (fire_to_c && (exp_idx_c == TAG_W'(t)));
      arm_now_c[t]    = (state_q == S_ISSUE1) && (req_tag_q == TAG_W'(t));
    end
    busy_d = (busy_q & ~retire_c) | alloc_mask_c;
    for (int unsigned t = 0; t < NTAG; t++) begin
      armed_d[t] = busy_d[t] && (armed_q[t] || arm_now_c[t]);
      if (arm_now_c[t]) begin
        cnt_d[t] = '0;
      end else if (armed_q[t] && (cnt_q[t] != CNT_MAX)) begin
        cnt_d[t] = cnt_q[t] + CNT_W'(1);
      end else begin
        cnt_d[t] = cnt_q[t];
      end
    end
    if (rsp_hit_c) begin
      cpl_valid_d = 1'b1;
      cpl_resp_d  = rsp_resp_in;
      cpl_data_d  = rsp_data_in;
      cpl_tag_d   = rsp_tag_in;
    end else if (fire_to_c) begin
      cpl_valid_d   = 1'b1;
      cpl_timeout_d = 1'b1;
      cpl_tag_d     = exp_idx_c;
    end
    op_ready_d = ((state_d == S_IDLE) || (state_d == S_ISSUE2)) && !(&busy_d);
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op_ready_q    <= 1'b0;
      req_cmd_q     <= 4'd0;
      req_data_q    <= '0;
      req_tag_q     <= '0;
      d2_q          <= '0;
      busy_q        <= '0;
      armed_q       <= '0;
      cpl_valid_q   <= 1'b0;
      cpl_resp_q    <= 2'd0;
      cpl_data_q    <= '0;
      cpl_tag_q     <= '0;
      cpl_timeout_q <= 1'b0;
      err_spur_q    <= 1'b0;
      for (int unsigned t = 0; t < NTAG; t++) cnt_q[t] <= '0;
    end else begin
      state_q       <= state_d;
      op_ready_q    <= op_ready_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      req_tag_q     <= req_tag_d;
      d2_q          <= d2_d;
      busy_q        <= busy_d;
      armed_q       <= armed_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_resp_q    <= cpl_resp_d;
      cpl_data_q    <= cpl_data_d;
      cpl_tag_q     <= cpl_tag_d;
      cpl_timeout_q <= cpl_timeout_d;
      err_spur_q    <= err_spur_d;
      for (int unsigned t = 0; t < NTAG; t++) cnt_q[t] <= cnt_d[t];
    end
  end

  assign op_ready     = op_ready_q;
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign req_tag_out  = req_tag_q;
  assign cpl_valid    = cpl_valid_q;
  assign cpl_resp     = cpl_resp_q;
  assign cpl_data     = cpl_data_q;
  assign cpl_tag      = cpl_tag_q;
  assign cpl_timeout  = cpl_timeout_q;
  assign err_spurious = err_spur_q;
  assign busy_tags    = busy_q;

endmodule

// File: tb/tb_calc2_port_issuer.sv
// Bench for calc2_port_issuer: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_calc2_port_issuer;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned NTAG    = 4;

  logic              c_clk = 1'b0;
  logic              reset = 1'b1;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [3:0]        op_cmd = '0;
  logic [DATA_W-1:0] op_d1 = '0, op_d2 = '0;
  logic [3:0]        req_cmd_out;
  logic [DATA_W-1:0] req_data_out;
  logic [TAG_W-1:0]  req_tag_out;
  logic [1:0]        rsp_resp_in = '0;
  logic [DATA_W-1:0] rsp_data_in = '0;
  logic [TAG_W-1:0]  rsp_tag_in = '0;
  logic              cpl_valid;
  logic [1:0]        cpl_resp;
  logic [DATA_W-1:0] cpl_data;
  logic [TAG_W-1:0]  cpl_tag;
  logic              cpl_timeout;
  logic              err_spurious;
  logic [NTAG-1:0]   busy_tags;

  always #5 c_clk = ~c_clk;

  calc2_port_issuer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd), .op_d1(op_d1), .op_d2(op_d2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .rsp_resp_in(rsp_resp_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_data(cpl_data), .cpl_tag(cpl_tag),
    .cpl_timeout(cpl_timeout), .err_spurious(err_spurious), .busy_tags(busy_tags)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tags carry the cycle number of their ISSUE2 beat.
  logic              e_ready = 0;
  logic [3:0]        e_cmd = 0;
  logic [DATA_W-1:0] e_data = 0;
  logic [TAG_W-1:0]  e_tag = 0;
  logic              e_cv = 0, e_cto = 0, e_spur = 0;
  logic [1:0]        e_cr = 0;
  logic [DATA_W-1:0] e_cd = 0;
  logic [TAG_W-1:0]  e_ct = 0;
  logic [NTAG-1:0]   e_busy = 0;

  int phase = 0;
  int cyc = 0;
  bit m_busy [NTAG];
  int m_i2 [NTAG];
  logic [3:0]        cur_cmd;
  logic [DATA_W-1:0] cur_a, cur_b;
  int                cur_tag;

  task automatic model_reset();
    phase = 0;
    for (int t = 0; t < int'(NTAG); t++) begin m_busy[t] = 0; m_i2[t] = -1; end
    e_ready = 0; e_cmd = 0; e_data = 0; e_tag = 0;
    e_cv = 0; e_cr = 0; e_cd = 0; e_ct = 0; e_cto = 0; e_spur = 0; e_busy = 0;
  endtask

  task automatic model_step();
    bit ob [NTAG];
    bit done;
    bit rdy;
    int t;
    cyc++;
    rdy = e_ready;
    for (int i = 0; i < int'(NTAG); i++) ob[i] = m_busy[i];
    e_cv = 0; e_cr = 0; e_cd = 0; e_ct = 0; e_cto = 0; e_spur = 0;
    done = 0;
    if (rsp_resp_in != 2'd0) begin
      if (ob[rsp_tag_in]) begin
        e_cv = 1; e_cr = rsp_resp_in; e_cd = rsp_data_in; e_ct = rsp_tag_in;
        m_busy[rsp_tag_in] = 0; m_i2[rsp_tag_in] = -1; done = 1;
      end else begin
        e_spur = 1;
      end
    end
    for (int i = 0; i < int'(NTAG); i++) begin
      if (!done && ob[i] && m_i2[i] >= 0 && (cyc - 1) - m_i2[i] >= int'(TIMEOUT) - 1) begin
        e_cv = 1; e_cto = 1; e_ct = TAG_W'(i);
        m_busy[i] = 0; m_i2[i] = -1; done = 1;
      end
    end
    if (op_valid && rdy) begin
      if (op_cmd != 4'd0) begin
        t = 0;
        while (ob[t]) t++;
        m_busy[t] = 1; m_i2[t] = -1;
        cur_cmd = op_cmd; cur_a = op_d1; cur_b = op_d2; cur_tag = t;
        phase = 1;
      end else begin
        phase = 0;
      end
    end else if (phase == 1) begin
      phase = 2;
      if (m_busy[cur_tag]) m_i2[cur_tag] = cyc;
    end else begin
      phase = 0;
    end
    case (phase)
      1: begin e_cmd = cur_cmd; e_data = cur_a; e_tag = TAG_W'(cur_tag); end
      2: begin e_cmd = 0; e_data = cur_b; e_tag = TAG_W'(cur_tag); end
      default: begin e_cmd = 0; e_data = 0; e_tag = 0; end
    endcase
    e_ready = 0;
    for (int i = 0; i < int'(NTAG); i++) begin
      e_busy[i] = m_busy[i];
      if (phase != 1 && !m_busy[i]) e_ready = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge c_clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge c_clk);
      chk("op_ready",     64'(op_ready),     64'(e_ready));
      chk("req_cmd",      64'(req_cmd_out),  64'(e_cmd));
      chk("req_data",     64'(req_data_out), 64'(e_data));
      chk("req_tag",      64'(req_tag_out),  64'(e_tag));
      chk("cpl_valid",    64'(cpl_valid),    64'(e_cv));
      chk("cpl_resp",     64'(cpl_resp),     64'(e_cr));
      chk("cpl_data",     64'(cpl_data),     64'(e_cd));
      chk("cpl_tag",      64'(cpl_tag),      64'(e_ct));
      chk("cpl_timeout",  64'(cpl_timeout),  64'(e_cto));
      chk("err_spurious", 64'(err_spurious), 64'(e_spur));
      chk("busy_tags",    64'(busy_tags),    64'(e_busy));
    end
  end

  int tb_cyc = 0;
  initial forever begin
    @(posedge c_clk);
    tb_cyc++;
  end

  // Offer an op and hold it until accepted; returns in the ISSUE1 cycle.
  task automatic send_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    op_valid = 1; op_cmd = c; op_d1 = a; op_d2 = b;
    while (!op_ready && n < 20) begin
      @(negedge c_clk);
      n++;
    end
    chk("send_op_ready", 64'(op_ready), 64'(1));
    @(negedge c_clk);
    op_valid = 0; op_cmd = 0;
  endtask

  // Present one response for a single cycle; returns in the completion cycle.
  task automatic respond(input logic [1:0] r, input logic [31:0] d, input logic [1:0] tg);
    rsp_resp_in = r; rsp_data_in = d; rsp_tag_in = tg;
    @(negedge c_clk);
    rsp_resp_in = 0; rsp_data_in = 0; rsp_tag_in = 0;
  endtask

  int issue_cyc [4];
  int n;

  initial begin
    #1 reset = 0;
    repeat (3) @(negedge c_clk);
    chk("lit_rst_ready", 64'(op_ready), 64'(0));
    chk("lit_rst_busy", 64'(busy_tags), 64'(0));
    reset = 1;
    @(negedge c_clk);
    chk("lit_ready_after_rst", 64'(op_ready), 64'(1));

    // add 5 + 7, answered with 12
    send_op(4'd1, 32'd5, 32'd7);
    chk("lit_s1_i1_cmd", 64'(req_cmd_out), 64'(1));
    chk("lit_s1_i1_data", 64'(req_data_out), 64'(5));
    chk("lit_s1_i1_tag", 64'(req_tag_out), 64'(0));
    @(negedge c_clk);
    chk("lit_s1_i2_cmd", 64'(req_cmd_out), 64'(0));
    chk("lit_s1_i2_data", 64'(req_data_out), 64'(7));
    respond(2'd1, 32'd12, 2'd0);
    chk("lit_s1_cpl_valid", 64'(cpl_valid), 64'(1));
    chk("lit_s1_cpl_resp", 64'(cpl_resp), 64'(1));
    chk("lit_s1_cpl_data", 64'(cpl_data), 64'(12));
    chk("lit_s1_busy", 64'(busy_tags), 64'(0));

    // cmd 0 is swallowed without a tag
    send_op(4'd0, 32'd9, 32'd9);
    chk("lit_cmd0_bus", 64'(req_cmd_out), 64'(0));
    chk("lit_cmd0_busy", 64'(busy_tags), 64'(0));

    // four back-to-back ops fill all tags
    for (int i = 0; i < 4; i++) begin
      send_op((i % 2 == 0) ? 4'd5 : 4'd6, 32'(10 + i), 32'(20 + i));
      issue_cyc[i] = tb_cyc;
      chk("lit_b2b_tag", 64'(req_tag_out), 64'(i));
      if (i > 0) chk("lit_b2b_spacing", 64'(issue_cyc[i] - issue_cyc[i-1]), 64'(2));
    end
    op_valid = 1; op_cmd = 4'd2; op_d1 = 32'd100; op_d2 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge c_clk);
      chk("lit_full_not_ready", 64'(op_ready), 64'(0));
    end
    respond(2'd1, 32'd55, 2'd2);
    chk("lit_free2_cpl_tag", 64'(cpl_tag), 64'(2));
    chk("lit_free2_busy", 64'(busy_tags), 64'(4'b1011));
    chk("lit_free2_ready", 64'(op_ready), 64'(1));
    @(negedge c_clk);
    op_valid = 0; op_cmd = 0;
    chk("lit_fifth_tag", 64'(req_tag_out), 64'(2));
    chk("lit_fifth_cmd", 64'(req_cmd_out), 64'(2));
    chk("lit_fifth_busy", 64'(busy_tags), 64'(4'b1111));
    respond(2'd2, 32'd1, 2'd0);
    respond(2'd1, 32'd2, 2'd1);
    respond(2'd3, 32'd3, 2'd3);
    respond(2'd1, 32'd4, 2'd2);
    @(negedge c_clk);
    chk("lit_drain_busy", 64'(busy_tags), 64'(0));

    // spurious response, then a lost response that times out
    send_op(4'd5, 32'h1, 32'h3);
    @(negedge c_clk);
    n = 0;
    respond(2'd1, 32'd77, 2'd3);
    n++;
    chk("lit_spur_pulse", 64'(err_spurious), 64'(1));
    chk("lit_spur_no_cpl", 64'(cpl_valid), 64'(0));
    chk("lit_spur_busy", 64'(busy_tags), 64'(4'b0001));
    while (!cpl_valid && n < 80) begin
      @(negedge c_clk);
      n++;
    end
    chk("lit_to_latency", 64'(n), 64'(64));
    chk("lit_to_flag", 64'(cpl_timeout), 64'(1));
    chk("lit_to_tag", 64'(cpl_tag), 64'(0));
    chk("lit_to_busy", 64'(busy_tags), 64'(0));

    // response on tag 1 collides with expiry of tag 0
    send_op(4'd6, 32'h80, 32'h2);
    @(negedge c_clk);
    send_op(4'd1, 32'd3, 32'd4);
    chk("lit_col_tag1", 64'(req_tag_out), 64'(1));
    repeat (62) @(negedge c_clk);
    respond(2'd2, 32'hdead, 2'd1);
    chk("lit_col_first_tag", 64'(cpl_tag), 64'(1));
    chk("lit_col_first_to", 64'(cpl_timeout), 64'(0));
    chk("lit_col_first_data", 64'(cpl_data), 64'(32'hdead));
    chk("lit_col_first_busy", 64'(busy_tags), 64'(4'b0001));
    @(negedge c_clk);
    chk("lit_col_second_valid", 64'(cpl_valid), 64'(1));
    chk("lit_col_second_to", 64'(cpl_timeout), 64'(1));
    chk("lit_col_second_tag", 64'(cpl_tag), 64'(0));
    chk("lit_col_busy", 64'(busy_tags), 64'(0));

    // reset in ISSUE2 with three tags outstanding
    send_op(4'd1, 32'd1, 32'd1);
    send_op(4'd2, 32'd2, 32'd2);
    send_op(4'd5, 32'd3, 32'd3);
    @(negedge c_clk);
    chk("lit_pre_rst_busy", 64'(busy_tags), 64'(4'b0111));
    #2 reset = 0;
    #1;
    chk("lit_rst_mid_busy", 64'(busy_tags), 64'(0));
    chk("lit_rst_mid_data", 64'(req_data_out), 64'(0));
    chk("lit_rst_mid_ready", 64'(op_ready), 64'(0));
    repeat (2) @(negedge c_clk);
    reset = 1;
    @(negedge c_clk);
    chk("lit_post_rst_ready", 64'(op_ready), 64'(1));
    chk("lit_post_rst_busy", 64'(busy_tags), 64'(0));
    send_op(4'd2, 32'd9, 32'd4);
    chk("lit_post_rst_tag", 64'(req_tag_out), 64'(0));
    @(negedge c_clk);
    respond(2'd1, 32'd5, 2'd0);
    repeat (3) @(negedge c_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc2_port_issuer.md
Name: calc2_port_issuer

Overview:
- Upstream request driver for one CALC2 requester port.
- Accepts whole operations (cmd, operand1, operand2) over a valid/ready handshake and allocates a free 2-bit tag.
- Drives the two-cycle CALC2 request protocol: cycle 1 carries cmd + operand1 + tag; cycle 2 carries cmd=0 + operand2.
- Consumes that port's out_data/out_resp/out_tag, retires tags, reports each completion, and times out lost responses.
- Four instances sit directly in front of calc2_top.

Parameters:
DATA_W, 32, operand/result width
TAG_W, 2, tag width; 2**TAG_W tags tracked (4 at default)
TIMEOUT, 64, cycles from ISSUE2 to declaring a tag lost (range 2..1023)

Ports:
c_clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
op_valid  in  1  operation offered
op_ready  out  1  issuer can accept
op_cmd  in  4  CALC2 command (1 add, 2 sub, 5 shl, 6 shr)
op_d1  in  DATA_W  operand1
op_d2  in  DATA_W  operand2
req_cmd_out  out  4  to reqN_cmd_in
req_data_out  out  DATA_W  to reqN_data_in
req_tag_out  out  TAG_W  to reqN_tag_in
rsp_resp_in  in  2  from out_respN; 0 = none, 1 ok, 2 over/underflow, 3 invalid
rsp_data_in  in  DATA_W  from out_dataN
rsp_tag_in  in  TAG_W  from out_tagN
cpl_valid  out  1  one-cycle completion pulse
cpl_resp  out  2  response code (0 when timeout)
cpl_data  out  DATA_W  result (0 when timeout)
cpl_tag  out  TAG_W  completed tag
cpl_timeout  out  1  qualifies cpl_valid: tag timed out
err_spurious  out  1  pulse: response for a tag not busy
busy_tags  out  2**TAG_W  outstanding-tag mask

Behaviour:
- Reset value of every output is 0 (op_ready included); all internal state is cleared and the FSM goes to IDLE.
- A reset asserted mid-operation abandons all in-flight tags with no completions.
- op_ready rises in the first cycle after reset deasserts.
- All outputs are registered.
- FSM states: IDLE, ISSUE1, ISSUE2.
- op_ready = (state is IDLE or ISSUE2) AND at least one tag is free in the registered busy mask.
- Handshake: op_valid and op_ready high at a rising edge. The issuer latches cmd/d1/d2, allocates the lowest-numbered free tag, sets its busy bit, and moves to ISSUE1.
- ISSUE1 (one cycle): req_cmd_out=cmd, req_data_out=d1, req_tag_out=tag.
- ISSUE2 (one cycle): req_cmd_out=0, req_data_out=d2, req_tag_out holds the tag.
  - Next state is ISSUE1 on a new handshake, otherwise IDLE.
  - Back-to-back throughput is one operation per 2 cycles.
- IDLE drives req_cmd_out, req_data_out and req_tag_out to 0.
- op_cmd=0 is accepted and discarded: no tag is allocated and there is no bus activity. The FSM stays in or returns to IDLE.
- Response (rsp_resp_in != 0) is sampled at a rising edge.
  - Tag busy: the next cycle gives cpl_valid=1, cpl_resp/data/tag = sampled values, cpl_timeout=0, and the busy bit clears.
  - Tag not busy: err_spurious=1 for one cycle, no cpl_valid, and state is unchanged.
- A response to a tag still in ISSUE1/ISSUE2 is matched normally.
- Timeout:
  - Each busy tag has a counter that starts at 0 in the ISSUE2 cycle and increments every cycle.
  - On reaching TIMEOUT-1 with no response, the next cycle gives cpl_valid=1, cpl_timeout=1, cpl_resp=0, cpl_data=0, cpl_tag=tag, and the busy bit clears.
- Only one completion is emitted per cycle. Priority order:
  1. response
  2. lowest-tag expired timeout
- A deferred timeout keeps its counter saturated and fires on the first free completion slot.
- A response and timeout on the same tag in the same cycle count as the response; no timeout is emitted.
- A tag freed in cycle N is allocatable only from cycle N+1 (registered mask). When all tags are busy, op_ready=0 until a completion.

Test Plan:
- Reset, then op add d1=5 d2=7 → ISSUE1 drives cmd=1,data=5,tag=0; ISSUE2 drives cmd=0,data=7; rsp resp=1,data=12,tag=0 → cpl_valid, cpl_resp=1, cpl_data=12, cpl_tag=0, busy_tags=0000.
- Five ops offered back-to-back with no responses → tags 0,1,2,3 issued at 2-cycle spacing; op_ready=0 for the fifth; respond to tag 2 → busy_tags=1011; fifth op takes tag 2 one cycle later.
- Issue one op, never respond, TIMEOUT=64 → cpl_timeout=1, cpl_tag=0 exactly 64 cycles after ISSUE2; busy_tags=0000.
- rsp resp=1 tag=3 while busy_tags=0001 → err_spurious pulse, no cpl_valid, mask unchanged.
- Response on tag 1 and expiry of tag 0 in the same cycle → cpl for tag 1 first, timeout cpl for tag 0 the following cycle.
- Assert reset during ISSUE2 with 3 tags busy → all outputs 0 immediately; after release, busy_tags=0000, op_ready=1, next op gets tag 0.
